pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the five-stage core. Drives the pipeline-register controls for the IF/ID and ID/EX registers: reset_t flush selects, hold enables, and the `exe_is_waiting` hold for multi-cycle mul/div in EX. Inputs are decode operand usage, EX-stage destination info, memory wait lines and the EX branch redirect. Purely a control block; no datapath passes through it.

Parameters:
MUL_LAT, 3, total EX-hold cycles for a multiply (>=1)
DIV_LAT, 64, total EX-hold cycles for a divide (>=1)
CNT_W, 7, latency counter width; must hold max(MUL_LAT,DIV_LAT)-1

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
Iwait  in  1  instruction fetch outstanding
Dwait  in  1  data access outstanding
id_rs1, id_rs2  in  5 each  decode source register indices
id_use_rs1, id_use_rs2  in  1 each  decode actually reads that source
ex_valid  in  1  EX holds a non-bubble instruction
ex_dst  in  5  EX destination register
ex_regwrite  in  1  EX writes the register file
ex_is_load  in  1  EX instruction is a load
ex_mc_start  in  1  EX instruction is a mul/div
ex_mc_is_div  in  1  selects DIV_LAT (1) or MUL_LAT (0)
redirect  in  1  EX resolved a taken branch/jump this cycle
stall_IF  out  1  hold PC/fetch
stall_ID  out  1  hold the IF/ID register
reset_IF_ID  out  reset_t  flush select for IF/ID
reset_ID_EX  out  reset_t  flush select for ID/EX
exe_is_waiting  out  1  hold ID/EX and EX
mc_done  out  1  mul/div result valid this cycle

Behaviour:
- Clock/reset: one clock `clk`; `reset` is synchronous and active-high.
- State on reset: FSM = S_RUN, cnt = 0, redirect_pending = 0.
- Outputs during reset: stall_* = 0, reset_* = RESET_RESET, exe_is_waiting = 0, mc_done = 0. The reset_* values are combinational with reset.
- FSM states: S_RUN, S_MC.
  - S_RUN & ex_valid & ex_mc_start & !Dwait: load cnt = LAT-1 (LAT per ex_mc_is_div) and go to S_MC.
  - S_MC & cnt != 0: decrement cnt every cycle, including while Dwait is high.
  - S_MC & cnt == 0 & !Dwait: return to S_RUN.
  - S_MC & cnt == 0 & Dwait: remain in S_MC.
- exe_is_waiting = (S_RUN & ex_valid & ex_mc_start) | (S_MC & cnt != 0). A mul/div therefore holds EX for exactly LAT cycles.
- mc_done = S_MC & cnt == 0 (combinational). It stays high while Dwait extends that cycle.
- Load-use hazard: ex_valid & ex_is_load & ex_regwrite & ex_dst != 0 & ((id_use_rs1 & id_rs1 == ex_dst) | (id_use_rs2 & id_rs2 == ex_dst)).
- Output priority, highest first:
  1. Dwait or exe_is_waiting: stall_IF = stall_ID = 1, reset_* = RESET_CONTINUE.
  2. redirect: stall_* = 0, reset_IF_ID = reset_ID_EX = RESET_RESET.
  3. Load-use: stall_IF = stall_ID = 1, reset_ID_EX = RESET_RESET, reset_IF_ID = RESET_CONTINUE.
  4. Iwait: stall_IF = 1, reset_IF_ID = RESET_RESET (bubble into ID).
  5. Otherwise: all 0 / RESET_CONTINUE.
- Redirect while Iwait: the in-flight fetch is wrong-path.
  - Set redirect_pending on redirect & Iwait.
  - While pending, force reset_IF_ID = RESET_RESET.
  - Clear pending on the first cycle with Iwait = 0, after that cycle's flush. That is the cycle the stale instruction returns.
  - redirect & !Iwait does not set pending.
- A redirect while exe_is_waiting cannot occur (EX is frozen) and is ignored.
- Reset mid-mul/div aborts immediately to S_RUN; mc_done is not asserted.
- Counter arithmetic is unsigned and never underflows (it is only decremented when nonzero).

Optional Feature:
PIPE_HAZARD_PERF_EN:
- Defined: adds outputs perf_stall_cycles[63:0] (cycles with stall_IF = 1) and perf_flush_cnt[63:0] (cycles with redirect & !exe_is_waiting). Both are reset to 0 and wrap modulo 2^64.
- Undefined: these ports and counters do not exist.

Decomposition:
- reset_t (RESET_CONTINUE / RESET_RESET) and the FSM state enum live in package common.
- Sub-module mc_latency_timer (counter plus done flag) is natural: inputs start/lat/hold, outputs waiting/done.
- Hazard detection and priority mux stay in the top block.

Test Plan:
- Mul with MUL_LAT=3: ex_mc_start at cycle 0 -> exe_is_waiting high cycles 0-2, mc_done at cycle 3, stall_IF high cycles 0-2.
- Div with Dwait high at its done cycle for 2 cycles -> mc_done held 2 extra cycles, exe_is_waiting 0, stall_IF = 1 from Dwait, then S_RUN.
- Load to x5 in EX, id_rs2 = 5 with id_use_rs2 = 1 -> one cycle of stall_IF = stall_ID = 1 and reset_ID_EX = RESET_RESET. The same case with ex_dst = 0 -> no stall.
- redirect & Iwait = 1 for 3 cycles -> reset_IF_ID = RESET_RESET on all 4 cycles including the Iwait-fall cycle; pending cleared after.
- redirect and load-use in the same cycle -> redirect wins: both reset_* = RESET_RESET, stall_* = 0.
- reset asserted at cnt = 30 of a div -> next cycle S_RUN, exe_is_waiting 0, no mc_done pulse.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline-control types: flush select and mul/div sequencer state.
// Latency: none (types only).
// Backpressure: not applicable.
package common;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

    typedef enum logic {
        S_RUN = 1'b0,
        S_MC  = 1'b1
    } mc_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_timer.sv
// Multi-cycle EX latency timer: holds EX for lat_m1+1 cycles, then flags done.
// Latency: done asserts lat_m1+1 cycles after start.
// Backpressure: hold keeps the done cycle alive; the countdown itself never pauses.
module mc_latency_timer
    import common::*;
#(
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] lat_m1,
    input  logic             hold,
    output logic             waiting,
    output logic             done
);

    mc_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        waiting   = 1'b0;
        done      = 1'b0;
        case (state)
            S_RUN: begin
                waiting = start;
                // A stalled data access keeps the instruction out of EX proper
                if (start && !hold) begin
                    cnt_nxt   = lat_m1;
                    state_nxt = S_MC;
                end
            end
            S_MC: begin
                if (cnt != '0) begin
                    waiting = 1'b1;
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    done = 1'b1;
                    if (!hold) state_nxt = S_RUN;
                end
            end
            default: state_nxt = S_RUN;
        endcase
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID and ID/EX; optional perf counters via PIPE_HAZARD_PERF_EN.
// Latency: all controls combinational from inputs; redirect_pending adds one registered bit.
// Backpressure: Dwait and mul/div occupancy freeze the front end, outranking redirect and load-use.
module pipe_hazard_ctrl
    import common::*;
#(
    parameter int MUL_LAT = 3,
    parameter int DIV_LAT = 64,
    parameter int CNT_W   = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Iwait,
    input  logic       Dwait,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_use_rs1,
    input  logic       id_use_rs2,
    input  logic       ex_valid,
    input  logic [4:0] ex_dst,
    input  logic       ex_regwrite,
    input  logic       ex_is_load,
    input  logic       ex_mc_start,
    input  logic       ex_mc_is_div,
    input  logic       redirect,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [63:0] perf_stall_cycles,
    output logic [63:0] perf_flush_cnt,
`endif
    output logic       stall_IF,
    output logic       stall_ID,
    output reset_t     reset_IF_ID,
    output reset_t     reset_ID_EX,
    output logic       exe_is_waiting,
    output logic       mc_done
);

    localparam logic [CNT_W-1:0] MUL_M1 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_M1 = CNT_W'(DIV_LAT - 1);

    logic             mc_waiting, mc_fin;
    logic [CNT_W-1:0] lat_m1;
    logic             load_use;
    logic             redirect_pending;

    assign lat_m1 = ex_mc_is_div ? DIV_M1 : MUL_M1;

    mc_latency_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (ex_valid & ex_mc_start),
        .lat_m1  (lat_m1),
        .hold    (Dwait),
        .waiting (mc_waiting),
        .done    (mc_fin)
    );

    assign exe_is_waiting = !reset && mc_waiting;
    assign mc_done        = !reset && mc_fin;

    assign load_use = ex_valid && ex_is_load && ex_regwrite && (ex_dst != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_dst)) ||
                       (id_use_rs2 && (id_rs2 == ex_dst)));

    always_comb begin
        stall_IF    = 1'b0;
        stall_ID    = 1'b0;
        reset_IF_ID = RESET_CONTINUE;
        reset_ID_EX = RESET_CONTINUE;
        if (reset) begin
            reset_IF_ID = RESET_RESET;
            reset_ID_EX = RESET_RESET;
        end else begin
            if (Dwait || exe_is_waiting) begin
                stall_IF = 1'b1;
                stall_ID = 1'b1;
            end else if (redirect) begin
                reset_IF_ID = RESET_RESET;
                reset_ID_EX = RESET_RESET;
            end else if (load_use) begin
                stall_IF    = 1'b1;
                stall_ID    = 1'b1;
                reset_ID_EX = RESET_RESET;
            end else if (Iwait) begin
                stall_IF    = 1'b1;
                reset_IF_ID = RESET_RESET;
            end
            // The fetch outstanding at redirect time is wrong-path; squash it on arrival
            if (redirect_pending) reset_IF_ID = RESET_RESET;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            redirect_pending <= 1'b0;
        else if (redirect && !exe_is_waiting && Iwait)
            redirect_pending <= 1'b1;
        else if (!Iwait)
            redirect_pending <= 1'b0;
    end

`ifdef PIPE_HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cycles <= '0;
            perf_flush_cnt    <= '0;
        end else begin
            if (stall_IF) perf_stall_cycles <= perf_stall_cycles + 64'd1;
            if (redirect && !exe_is_waiting) perf_flush_cnt <= perf_flush_cnt + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with hand-computed control vectors.
// Vector order: {stall_IF, stall_ID, reset_IF_ID, reset_ID_EX, exe_is_waiting, mc_done}.
module tb_pipe_hazard_ctrl;
    import common::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       Iwait, Dwait;
    logic [4:0] id_rs1, id_rs2;
    logic       id_use_rs1, id_use_rs2;
    logic       ex_valid;
    logic [4:0] ex_dst;
    logic       ex_regwrite, ex_is_load, ex_mc_start, ex_mc_is_div;
    logic       redirect;
    logic       stall_IF, stall_ID;
    reset_t     reset_IF_ID, reset_ID_EX;
    logic       exe_is_waiting, mc_done;
`ifdef PIPE_HAZARD_PERF_EN
    logic [63:0] perf_stall_cycles, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(3), .DIV_LAT(64), .CNT_W(7)) dut (
        .clk            (clk),
        .reset          (reset),
        .Iwait          (Iwait),
        .Dwait          (Dwait),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .id_use_rs1     (id_use_rs1),
        .id_use_rs2     (id_use_rs2),
        .ex_valid       (ex_valid),
        .ex_dst         (ex_dst),
        .ex_regwrite    (ex_regwrite),
        .ex_is_load     (ex_is_load),
        .ex_mc_start    (ex_mc_start),
        .ex_mc_is_div   (ex_mc_is_div),
        .redirect       (redirect),
`ifdef PIPE_HAZARD_PERF_EN
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_cnt    (perf_flush_cnt),
`endif
        .stall_IF       (stall_IF),
        .stall_ID       (stall_ID),
        .reset_IF_ID    (reset_IF_ID),
        .reset_ID_EX    (reset_ID_EX),
        .exe_is_waiting (exe_is_waiting),
        .mc_done        (mc_done)
    );

    logic [5:0] obs;
    assign obs = {stall_IF, stall_ID, reset_IF_ID, reset_ID_EX, exe_is_waiting, mc_done};

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", tag, got, exp);
    endtask

    // Sample mid-cycle, then move to just after the next rising edge
    task automatic step(input string tag, input logic [5:0] exp);
        @(negedge clk);
        check_eq(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        Iwait = 0; Dwait = 0; id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_valid = 0; ex_dst = 0; ex_regwrite = 0; ex_is_load = 0;
        ex_mc_start = 0; ex_mc_is_div = 0; redirect = 0;
    endtask

    task automatic set_load_x5();
        ex_valid = 1; ex_is_load = 1; ex_regwrite = 1; ex_dst = 5'd5;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        step("reset_state", 6'b001100);
        reset = 0;
        step("idle", 6'b000000);

        // Multiply, MUL_LAT = 3
        ex_valid = 1; ex_mc_start = 1; ex_mc_is_div = 0;
        step("mul_c0", 6'b110010);
        step("mul_c1", 6'b110010);
        step("mul_c2", 6'b110010);
        step("mul_done", 6'b000001);
        idle_inputs();
        step("mul_after", 6'b000000);

        // Divide, DIV_LAT = 64, Dwait stretches the done cycle by two
        ex_valid = 1; ex_mc_start = 1; ex_mc_is_div = 1;
        for (int i = 0; i < 64; i++) step($sformatf("div_wait%0d", i), 6'b110010);
        Dwait = 1;
        step("div_done_dw0", 6'b110001);
        step("div_done_dw1", 6'b110001);
        Dwait = 0;
        step("div_done_last", 6'b000001);
        idle_inputs();
        step("div_after", 6'b000000);

        // Load-use
        set_load_x5(); id_rs2 = 5'd5; id_use_rs2 = 1;
        step("lu_rs2", 6'b110100);
        ex_dst = 5'd0; id_rs2 = 5'd0;
        step("lu_x0", 6'b000000);
        ex_dst = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 0;
        step("lu_unused", 6'b000000);
        id_rs1 = 5'd5; id_use_rs1 = 1;
        step("lu_rs1", 6'b110100);
        ex_regwrite = 0;
        step("lu_nowrite", 6'b000000);
        ex_regwrite = 1; redirect = 1;
        step("redir_over_lu", 6'b001100);
        idle_inputs();

        // Redirect with fetch outstanding
        redirect = 1; Iwait = 1;
        step("ri_c0", 6'b001100);
        redirect = 0;
        step("ri_c1", 6'b101000);
        step("ri_c2", 6'b101000);
        Iwait = 0;
        step("ri_fall", 6'b001000);
        step("ri_cleared", 6'b000000);

        // Redirect without fetch outstanding leaves nothing pending
        redirect = 1;
        step("r_noiwait", 6'b001100);
        redirect = 0;
        step("r_noiwait_after", 6'b000000);

        Iwait = 1;
        step("iwait_only", 6'b101000);
        Iwait = 0; Dwait = 1; redirect = 1;
        step("dwait_over_redir", 6'b110000);
        idle_inputs();

        // Reset while a divide is at cnt = 30
        ex_valid = 1; ex_mc_start = 1; ex_mc_is_div = 1;
        for (int i = 0; i < 34; i++) step($sformatf("div2_wait%0d", i), 6'b110010);
        reset = 1;
        step("div2_reset", 6'b001100);
        reset = 0; idle_inputs();
        step("div2_post0", 6'b000000);
        step("div2_post1", 6'b000000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
